// File: rtl/rf68000_nic_pkg.sv
// Shared ring-packet definitions for the rf68000 NIC, ring switch and CPU side.
// The packet fields and constants here are used by the NIC whether or not RF68000_NIC_BCAST_EN is defined.
package rf68000_nic_pkg;

    localparam int         ID_W     = 4;
    localparam logic [3:0] AGE_MAX  = 4'd15;
    localparam logic [3:0] BCAST_ID = 4'hF;

    typedef enum logic [3:0] {
        PT_NOP   = 4'd0,
        PT_WR    = 4'd1,
        PT_RD    = 4'd2,
        PT_RDACK = 4'd3
    } pkt_type_e;

    // Type is kept as raw bits: unknown codes must travel as NOP, not be coerced.
    typedef struct packed {
        logic [3:0]      ptype;
        logic [3:0]      age;
        logic [ID_W-1:0] did;
        logic [ID_W-1:0] sid;
        logic [3:0]      sel;
        logic [31:0]     adr;
        logic [31:0]     dat;
    } pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RESP = 2'd2
    } nic_state_e;

    function automatic logic pkt_is_live(input logic [3:0] ptype);
        return (ptype == PT_WR) || (ptype == PT_RD) || (ptype == PT_RDACK);
    endfunction

    function automatic logic [3:0] pkt_age_next(input logic [3:0] age);
        return age + 4'd1;
    endfunction

endpackage

// File: rtl/rf68000_nic_slot_mux.sv
// Outgoing slot selection: forwarded packet, then held read reply, then local tx.
module rf68000_nic_slot_mux
    import rf68000_nic_pkg::*;
(
    input  logic fwd_valid,
    input  pkt_t fwd_pkt,
    input  logic resp_valid,
    input  pkt_t resp_pkt,
    input  logic tx_valid,
    input  pkt_t tx_pkt,
    output pkt_t slot_pkt,
    output logic resp_take,
    output logic tx_take
);

    // Fixed-priority fill of the outgoing slot, aging anything that passes through
    always_comb begin
        slot_pkt  = '0;
        resp_take = 1'b0;
        tx_take   = 1'b0;
        if (fwd_valid) begin
            slot_pkt     = fwd_pkt;
            slot_pkt.age = pkt_age_next(fwd_pkt.age);
        end else if (resp_valid) begin
            slot_pkt  = resp_pkt;
            resp_take = 1'b1;
        end else if (tx_valid) begin
            slot_pkt = tx_pkt;
            tx_take  = 1'b1;
        end else begin
            slot_pkt = '0;
        end
    end

endmodule

// File: rtl/rf68000_nic_ring.sv
// Ring NIC for one rf68000 node: consumes/forwards ring slots and masters the node arbiter.
// Optional broadcast writes are enabled with `define RF68000_NIC_BCAST_EN.
module rf68000_nic_ring
    import rf68000_nic_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [ID_W-1:0] id,
    input  logic [83:0]     pkt_i,
    output logic [83:0]     pkt_o,
    output logic            nic_cyc,
    output logic            nic_stb,
    output logic            nic_we,
    output logic [3:0]      nic_sel,
    output logic [31:0]     nic_adr,
    output logic [31:0]     nic_dato,
    input  logic            nic_ack,
    input  logic [31:0]     nic_dati,
    input  logic            tx_req,
    input  logic [3:0]      tx_type,
    input  logic [ID_W-1:0] tx_did,
    input  logic [3:0]      tx_sel,
    input  logic [31:0]     tx_adr,
    input  logic [31:0]     tx_dat,
    output logic            tx_ack,
    output logic            rx_valid,
    output logic [ID_W-1:0] rx_sid,
    output logic [31:0]     rx_dat,
    output logic [15:0]     drop_cnt
);

    nic_state_e      state_r, state_s;
    pkt_t            in_s, resp_pkt_s, tx_pkt_s, slot_s, pkt_r;
    logic            busy_s, for_me_s, bcast_s, bcast_home_s;
    logic            rx_hit_s, capture_s, fwd_s, drop_s;
    logic            resp_valid_s, resp_take_s, tx_ok_s, tx_take_s;
    logic            cyc_s, we_s;
    logic            req_wr_r;
    logic [ID_W-1:0] req_sid_r;
    logic [31:0]     req_adr_r, resp_dat_r;
    logic            nic_cyc_r, nic_we_r, tx_ack_r, rx_valid_r;
    logic [3:0]      nic_sel_r;
    logic [31:0]     nic_adr_r, nic_dato_r, rx_dat_r;
    logic [ID_W-1:0] rx_sid_r;
    logic [15:0]     drop_cnt_r;

    assign in_s     = pkt_t'(pkt_i);
    assign busy_s   = (state_r != ST_IDLE);
    assign for_me_s = (in_s.did == id);

`ifdef RF68000_NIC_BCAST_EN
    assign bcast_s      = (in_s.ptype == PT_WR) && (in_s.did == BCAST_ID) && (in_s.sid != id);
    assign bcast_home_s = (in_s.ptype == PT_WR) && (in_s.did == BCAST_ID) && (in_s.sid == id);
`else
    assign bcast_s      = 1'b0;
    assign bcast_home_s = 1'b0;
`endif

    // Classify the incoming slot; "still busy" on the return-to-idle edge falls out of using state_r
    always_comb begin
        rx_hit_s  = 1'b0;
        capture_s = 1'b0;
        fwd_s     = 1'b0;
        drop_s    = 1'b0;
        if (!pkt_is_live(in_s.ptype)) begin
            fwd_s = 1'b0;
        end else if (for_me_s && (in_s.ptype == PT_RDACK)) begin
            rx_hit_s = 1'b1;
        end else if (for_me_s) begin
            capture_s = !busy_s;
            fwd_s     = busy_s;
        end else if (bcast_home_s) begin
            fwd_s = 1'b0;
        end else begin
            capture_s = bcast_s && !busy_s;
            if (in_s.age == AGE_MAX) begin
                drop_s = 1'b1;
            end else begin
                fwd_s = 1'b1;
            end
        end
    end

    assign resp_valid_s = (state_r == ST_RESP);
    // Requester drops tx_req only after seeing tx_ack, so skip the edge where the ack is visible
    assign tx_ok_s      = tx_req && !tx_ack_r;

    assign resp_pkt_s = '{ptype: PT_RDACK, age: 4'd0, did: req_sid_r, sid: id,
                          sel: nic_sel_r, adr: req_adr_r, dat: resp_dat_r};
    assign tx_pkt_s   = '{ptype: tx_type, age: 4'd0, did: tx_did, sid: id,
                          sel: tx_sel, adr: tx_adr, dat: tx_dat};

    rf68000_nic_slot_mux u_slot_mux (
        .fwd_valid  (fwd_s),
        .fwd_pkt    (in_s),
        .resp_valid (resp_valid_s),
        .resp_pkt   (resp_pkt_s),
        .tx_valid   (tx_ok_s),
        .tx_pkt     (tx_pkt_s),
        .slot_pkt   (slot_s),
        .resp_take  (resp_take_s),
        .tx_take    (tx_take_s)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_s) state_s = ST_WB;
                else           state_s = ST_IDLE;
            end
            ST_WB: begin
                if (nic_ack) state_s = req_wr_r ? ST_IDLE : ST_RESP;
                else         state_s = ST_WB;
            end
            ST_RESP: begin
                if (resp_take_s) state_s = ST_IDLE;
                else             state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of the registered Wishbone strobes
    always_comb begin
        cyc_s = 1'b0;
        we_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    cyc_s = 1'b1;
                    we_s  = (in_s.ptype == PT_WR);
                end else begin
                    cyc_s = 1'b0;
                end
            end
            ST_WB: begin
                if (!nic_ack) begin
                    cyc_s = 1'b1;
                    we_s  = req_wr_r;
                end else begin
                    cyc_s = 1'b0;
                end
            end
            default: cyc_s = 1'b0;
        endcase
    end

    // Request capture, Wishbone address/data and read-data latch
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            nic_cyc_r  <= 1'b0;
            nic_we_r   <= 1'b0;
            nic_sel_r  <= 4'd0;
            nic_adr_r  <= 32'd0;
            nic_dato_r <= 32'd0;
            req_wr_r   <= 1'b0;
            req_sid_r  <= '0;
            req_adr_r  <= 32'd0;
            resp_dat_r <= 32'd0;
        end else begin
            nic_cyc_r <= cyc_s;
            nic_we_r  <= we_s;
            if (capture_s) begin
                req_wr_r   <= (in_s.ptype == PT_WR);
                req_sid_r  <= in_s.sid;
                req_adr_r  <= in_s.adr;
                nic_sel_r  <= in_s.sel;
                nic_adr_r  <= {8'hFF, id, in_s.adr[19:0]};
                nic_dato_r <= in_s.dat;
            end
            if ((state_r == ST_WB) && nic_ack) begin
                resp_dat_r <= nic_dati;
            end
        end
    end

    // Ring-side registered outputs: slot, handshakes, reply delivery and drop counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pkt_r      <= '0;
            tx_ack_r   <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_sid_r   <= '0;
            rx_dat_r   <= 32'd0;
            drop_cnt_r <= 16'd0;
        end else begin
            pkt_r      <= slot_s;
            tx_ack_r   <= tx_take_s;
            rx_valid_r <= rx_hit_s;
            if (rx_hit_s) begin
                rx_sid_r <= in_s.sid;
                rx_dat_r <= in_s.dat;
            end
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    assign pkt_o    = pkt_r;
    assign nic_cyc  = nic_cyc_r;
    assign nic_stb  = nic_cyc_r;
    assign nic_we   = nic_we_r;
    assign nic_sel  = nic_sel_r;
    assign nic_adr  = nic_adr_r;
    assign nic_dato = nic_dato_r;
    assign tx_ack   = tx_ack_r;
    assign rx_valid = rx_valid_r;
    assign rx_sid   = rx_sid_r;
    assign rx_dat   = rx_dat_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_rf68000_nic_ring.sv
// Bench for rf68000_nic_ring: directed scenarios plus a randomized run against a queue-based node model.
module tb_rf68000_nic_ring;
    import rf68000_nic_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [3:0]  id;
    logic [83:0] pkt_i, pkt_o;
    logic        nic_cyc, nic_stb, nic_we, nic_ack;
    logic [3:0]  nic_sel;
    logic [31:0] nic_adr, nic_dato, nic_dati;
    logic        tx_req, tx_ack, rx_valid;
    logic [3:0]  tx_type, tx_did, tx_sel, rx_sid;
    logic [31:0] tx_adr, tx_dat, rx_dat;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    rf68000_nic_ring dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .id(id), .pkt_i(pkt_i), .pkt_o(pkt_o),
        .nic_cyc(nic_cyc), .nic_stb(nic_stb), .nic_we(nic_we), .nic_sel(nic_sel),
        .nic_adr(nic_adr), .nic_dato(nic_dato), .nic_ack(nic_ack), .nic_dati(nic_dati),
        .tx_req(tx_req), .tx_type(tx_type), .tx_did(tx_did), .tx_sel(tx_sel),
        .tx_adr(tx_adr), .tx_dat(tx_dat), .tx_ack(tx_ack), .rx_valid(rx_valid),
        .rx_sid(rx_sid), .rx_dat(rx_dat), .drop_cnt(drop_cnt)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [83:0] mk(input logic [3:0] t, input logic [3:0] a, input logic [3:0] d,
                                       input logic [3:0] s, input logic [3:0] sel,
                                       input logic [31:0] adr, input logic [31:0] dat);
        return {t, a, d, s, sel, adr, dat};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        pkt_i = '0; nic_ack = 1'b0; nic_dati = 32'd0; tx_req = 1'b0;
        tx_type = 4'd0; tx_did = 4'd0; tx_sel = 4'd0; tx_adr = 32'd0; tx_dat = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        id = 4'd3; rst_ni = 1'b0;
        pkt_i = mk(PT_RDACK, 4'd0, 4'd3, 4'd9, 4'hF, 32'd1, 32'd2);
        tx_req = 1'b1; tx_type = PT_WR;
        tick(); tick();
        n_cmp++; if (pkt_o !== 84'd0)   begin n_bad++; $display("FAIL rst_pkt_o got %h want 0", pkt_o); end
        n_cmp++; if (nic_cyc !== 1'b0)  begin n_bad++; $display("FAIL rst_nic_cyc got %b want 0", nic_cyc); end
        n_cmp++; if ({tx_ack, rx_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_pulses got %b want 00", {tx_ack, rx_valid}); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt); end
        n_cmp++; if (nic_adr !== 32'd0) begin n_bad++; $display("FAIL rst_nic_adr got %h want 0", nic_adr); end
        idle_inputs(); rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_remote_write();
        pkt_i = mk(PT_WR, 4'd0, 4'd3, 4'd1, 4'hF, 32'h100, 32'hDEADBEEF);
        tick(); pkt_i = '0;
        n_cmp++; if ({nic_cyc, nic_stb, nic_we} !== 3'b111) begin n_bad++; $display("FAIL wr_strobes got %b want 111", {nic_cyc, nic_stb, nic_we}); end
        n_cmp++; if (nic_adr !== 32'hFF300100) begin n_bad++; $display("FAIL wr_adr got %h want FF300100", nic_adr); end
        n_cmp++; if (nic_dato !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_dato got %h want DEADBEEF", nic_dato); end
        n_cmp++; if (nic_sel !== 4'hF) begin n_bad++; $display("FAIL wr_sel got %h want F", nic_sel); end
        n_cmp++; if (pkt_o !== 84'd0) begin n_bad++; $display("FAIL wr_slot_free got %h want 0", pkt_o); end
        tick(); tick();
        n_cmp++; if (nic_cyc !== 1'b1) begin n_bad++; $display("FAIL wr_cyc_hold got %b want 1", nic_cyc); end
        nic_ack = 1'b1; tick(); nic_ack = 1'b0;
        n_cmp++; if (nic_cyc !== 1'b0) begin n_bad++; $display("FAIL wr_cyc_drop got %b want 0", nic_cyc); end
        tick();
        n_cmp++; if (pkt_o !== 84'd0) begin n_bad++; $display("FAIL wr_no_reply got %h want 0", pkt_o); end
    endtask

    task automatic test_remote_read();
        pkt_i = mk(PT_RD, 4'd0, 4'd3, 4'd5, 4'hF, 32'h40, 32'h0BADF00D);
        tick(); pkt_i = '0;
        n_cmp++; if ({nic_cyc, nic_we} !== 2'b10) begin n_bad++; $display("FAIL rd_strobes got %b want 10", {nic_cyc, nic_we}); end
        n_cmp++; if (nic_adr !== 32'hFF300040) begin n_bad++; $display("FAIL rd_adr got %h want FF300040", nic_adr); end
        repeat (3) tick();
        nic_ack = 1'b1; nic_dati = 32'h12345678;
        tick(); nic_ack = 1'b0; nic_dati = 32'd0;
        n_cmp++; if ({nic_cyc, pkt_o} !== 85'd0) begin n_bad++; $display("FAIL rd_ack_edge got cyc=%b pkt=%h want 0/0", nic_cyc, pkt_o); end
        tick();
        n_cmp++; if (pkt_o !== mk(PT_RDACK, 4'd0, 4'd5, 4'd3, 4'hF, 32'h40, 32'h12345678)) begin
            n_bad++; $display("FAIL rd_reply got %h want %h", pkt_o, mk(PT_RDACK, 4'd0, 4'd5, 4'd3, 4'hF, 32'h40, 32'h12345678)); end
        tick();
        n_cmp++; if (pkt_o !== 84'd0) begin n_bad++; $display("FAIL rd_reply_once got %h want 0", pkt_o); end
    endtask

    task automatic test_busy_forward();
        pkt_i = mk(PT_WR, 4'd0, 4'd3, 4'd1, 4'hF, 32'h100, 32'h1111);
        tick();
        pkt_i = mk(PT_WR, 4'd2, 4'd3, 4'd6, 4'h3, 32'h200, 32'h2222);
        tick(); pkt_i = '0;
        n_cmp++; if (pkt_o !== mk(PT_WR, 4'd3, 4'd3, 4'd6, 4'h3, 32'h200, 32'h2222)) begin
            n_bad++; $display("FAIL busy_fwd got %h want age 3 copy", pkt_o); end
        n_cmp++; if ({nic_adr, nic_dato} !== {32'hFF300100, 32'h1111}) begin
            n_bad++; $display("FAIL busy_keep_req got %h/%h want FF300100/1111", nic_adr, nic_dato); end
        tick();
        nic_ack = 1'b1; pkt_i = mk(PT_RD, 4'd5, 4'd3, 4'd2, 4'hF, 32'h300, 32'd0);
        tick(); nic_ack = 1'b0; pkt_i = '0;
        n_cmp++; if (pkt_o !== mk(PT_RD, 4'd6, 4'd3, 4'd2, 4'hF, 32'h300, 32'd0)) begin
            n_bad++; $display("FAIL busy_ack_edge_fwd got %h want age 6 copy", pkt_o); end
        tick(); tick();
        n_cmp++; if (nic_cyc !== 1'b0) begin n_bad++; $display("FAIL busy_no_second_cyc got %b want 0", nic_cyc); end
    endtask

    task automatic test_age_out();
        logic exp_cyc;
        pkt_i = mk(PT_WR, 4'd15, 4'd7, 4'd1, 4'hF, 32'h10, 32'hAA);
        tick(); pkt_i = '0;
        n_cmp++; if ({pkt_o, drop_cnt} !== {84'd0, 16'd1}) begin n_bad++; $display("FAIL age_drop got %h cnt %0d want 0 cnt 1", pkt_o, drop_cnt); end
        pkt_i = mk(PT_WR, 4'd14, 4'd7, 4'd1, 4'hF, 32'h10, 32'hAA);
        tick(); pkt_i = '0;
        n_cmp++; if (pkt_o !== mk(PT_WR, 4'd15, 4'd7, 4'd1, 4'hF, 32'h10, 32'hAA)) begin
            n_bad++; $display("FAIL age_14_fwd got %h want age 15 copy", pkt_o); end
        n_cmp++; if (drop_cnt !== 16'd1) begin n_bad++; $display("FAIL age_cnt_hold got %0d want 1", drop_cnt); end
        pkt_i = mk(PT_WR, 4'd15, 4'hF, 4'd1, 4'hF, 32'h20, 32'hBB);
        tick(); pkt_i = '0;
`ifdef RF68000_NIC_BCAST_EN
        exp_cyc = 1'b1;
`else
        exp_cyc = 1'b0;
`endif
        n_cmp++; if ({pkt_o, drop_cnt, nic_cyc} !== {84'd0, 16'd2, exp_cyc}) begin
            n_bad++; $display("FAIL bcast_aged got %h cnt %0d cyc %b want 0 cnt 2 cyc %b", pkt_o, drop_cnt, nic_cyc, exp_cyc); end
        if (nic_cyc) begin nic_ack = 1'b1; tick(); nic_ack = 1'b0; end
        tick();
    endtask

    task automatic test_contention();
        pkt_i = mk(PT_RD, 4'd0, 4'd3, 4'd5, 4'hF, 32'h80, 32'd0);
        tick(); pkt_i = '0; tick();
        nic_ack = 1'b1; nic_dati = 32'hCAFEF00D;
        tick(); nic_ack = 1'b0;
        tx_req = 1'b1; tx_type = PT_WR; tx_did = 4'd9; tx_sel = 4'h3; tx_adr = 32'h1234; tx_dat = 32'h5555AAAA;
        tick();
        n_cmp++; if ({pkt_o, tx_ack} !== {mk(PT_RDACK, 4'd0, 4'd5, 4'd3, 4'hF, 32'h80, 32'hCAFEF00D), 1'b0}) begin
            n_bad++; $display("FAIL cont_resp_first got %h ack %b", pkt_o, tx_ack); end
        tick();
        n_cmp++; if ({pkt_o, tx_ack} !== {mk(PT_WR, 4'd0, 4'd9, 4'd3, 4'h3, 32'h1234, 32'h5555AAAA), 1'b1}) begin
            n_bad++; $display("FAIL cont_tx_next got %h ack %b", pkt_o, tx_ack); end
        tx_req = 1'b0;
        tick();
        n_cmp++; if ({pkt_o, tx_ack} !== 85'd0) begin n_bad++; $display("FAIL cont_tx_once got %h ack %b want 0", pkt_o, tx_ack); end
        tx_req = 1'b1; tx_type = PT_RD; tx_did = 4'd4; tx_adr = 32'h44;
        pkt_i = mk(PT_RDACK, 4'd7, 4'd3, 4'd9, 4'hF, 32'd0, 32'h87654321);
        tick(); pkt_i = '0; tx_req = 1'b0;
        n_cmp++; if ({rx_valid, rx_sid, rx_dat, tx_ack} !== {1'b1, 4'd9, 32'h87654321, 1'b1}) begin
            n_bad++; $display("FAIL rx_tx_same got v%b sid %h dat %h ack %b", rx_valid, rx_sid, rx_dat, tx_ack); end
        n_cmp++; if (pkt_o !== mk(PT_RD, 4'd0, 4'd4, 4'd3, 4'h3, 32'h44, 32'h5555AAAA)) begin
            n_bad++; $display("FAIL rx_tx_slot got %h", pkt_o); end
        tick();
        n_cmp++; if ({rx_valid, tx_ack} !== 2'b00) begin n_bad++; $display("FAIL rx_tx_pulse got %b want 00", {rx_valid, tx_ack}); end
    endtask

    task automatic test_tx_abort();
        tx_req = 1'b1; tx_type = PT_WR; tx_did = 4'd2; tx_sel = 4'h1; tx_adr = 32'h9; tx_dat = 32'h9;
        for (int i = 0; i < 4; i++) begin
            pkt_i = mk(PT_WR, 4'(i), 4'd7, 4'd1, 4'hF, 32'(i), 32'hE0);
            tick();
            n_cmp++; if ({pkt_o, tx_ack} !== {mk(PT_WR, 4'(i + 1), 4'd7, 4'd1, 4'hF, 32'(i), 32'hE0), 1'b0}) begin
                n_bad++; $display("FAIL abort_fwd%0d got %h ack %b", i, pkt_o, tx_ack); end
        end
        tx_req = 1'b0; pkt_i = '0;
        tick(); tick();
        n_cmp++; if ({pkt_o, tx_ack} !== 85'd0) begin n_bad++; $display("FAIL abort_nothing got %h ack %b want 0", pkt_o, tx_ack); end
    endtask

    task automatic test_reset_mid();
        pkt_i = mk(PT_WR, 4'd0, 4'd3, 4'd1, 4'hF, 32'h500, 32'h77);
        tick(); pkt_i = '0;
        n_cmp++; if (nic_cyc !== 1'b1) begin n_bad++; $display("FAIL mid_cyc_up got %b want 1", nic_cyc); end
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        n_cmp++; if ({nic_cyc, pkt_o, nic_adr} !== 117'd0) begin n_bad++; $display("FAIL mid_rst got cyc %b pkt %h adr %h", nic_cyc, pkt_o, nic_adr); end
        pkt_i = mk(PT_RD, 4'd0, 4'd3, 4'd2, 4'hF, 32'h600, 32'd0);
        tick(); pkt_i = '0;
        n_cmp++; if ({nic_cyc, nic_adr} !== {1'b1, 32'hFF300600}) begin n_bad++; $display("FAIL mid_idle_capture got cyc %b adr %h", nic_cyc, nic_adr); end
        nic_ack = 1'b1; nic_dati = 32'h600D;
        tick(); nic_ack = 1'b0; tick();
        n_cmp++; if (pkt_o !== mk(PT_RDACK, 4'd0, 4'd2, 4'd3, 4'hF, 32'h600, 32'h600D)) begin
            n_bad++; $display("FAIL mid_reply got %h", pkt_o); end
        tick();
    endtask

    // Randomized traffic; the model tracks the node only as "one job in service" and "replies waiting"
    task automatic test_random();
        pkt_t   job_q[$];
        pkt_t   rep_q[$];
        pkt_t   p, fwd, e_pkt, j;
        int     dropm = 0;
        int     wait_ack = -1;
        bit     busy, slot_free, newjob, e_rx, e_tx, live, acked_prev;
        logic [3:0]  e_rxsid;
        logic [31:0] e_rxdat;
        idle_inputs();
        id = 4'($urandom_range(0, 14));
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        acked_prev = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            p.ptype = ($urandom_range(0, 9) < 2) ? 4'd0 :
                      ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(1, 3));
            p.age   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 15));
            p.did   = ($urandom_range(0, 2) == 0) ? id : 4'($urandom_range(0, 15));
            p.sid   = 4'($urandom_range(0, 15));
            p.sel   = 4'($urandom_range(0, 15));
            p.adr   = $urandom;
            p.dat   = $urandom;
            pkt_i   = p;
            if (!tx_req && !acked_prev && ($urandom_range(0, 3) == 0)) begin
                tx_req = 1'b1; tx_type = 4'($urandom_range(1, 3)); tx_did = 4'($urandom_range(0, 15));
                tx_sel = 4'($urandom_range(0, 15)); tx_adr = $urandom; tx_dat = $urandom;
            end else if (tx_req && ($urandom_range(0, 15) == 0)) begin
                tx_req = 1'b0;
            end
            nic_ack = 1'b0; nic_dati = $urandom;
            if (nic_cyc) begin
                if (wait_ack < 0) wait_ack = $urandom_range(0, 4);
                if (wait_ack == 0) nic_ack = 1'b1;
                wait_ack--;
            end

            busy = (job_q.size() != 0) || (rep_q.size() != 0);
            live = (p.ptype >= 4'd1) && (p.ptype <= 4'd3);
            fwd = p; fwd.age = p.age + 4'd1;
            slot_free = 1'b1; newjob = 1'b0; e_rx = 1'b0; e_tx = 1'b0; e_pkt = '0;
            e_rxsid = p.sid; e_rxdat = p.dat;
            if (!live) begin
                slot_free = 1'b1;
            end else if (p.did == id && p.ptype == PT_RDACK) begin
                e_rx = 1'b1;
            end else if (p.did == id) begin
                if (busy) begin slot_free = 1'b0; e_pkt = fwd; end
                else newjob = 1'b1;
`ifdef RF68000_NIC_BCAST_EN
            end else if (p.ptype == PT_WR && p.did == 4'hF && p.sid == id) begin
                slot_free = 1'b1;
`endif
            end else begin
`ifdef RF68000_NIC_BCAST_EN
                if (p.ptype == PT_WR && p.did == 4'hF && !busy) newjob = 1'b1;
`endif
                if (p.age == AGE_MAX) begin
                    if (dropm < 65535) dropm++;
                end else begin
                    slot_free = 1'b0; e_pkt = fwd;
                end
            end
            if (slot_free) begin
                if (rep_q.size() != 0) e_pkt = rep_q.pop_front();
                else if (tx_req) begin
                    e_pkt = {tx_type, 4'd0, tx_did, id, tx_sel, tx_adr, tx_dat};
                    e_tx = 1'b1;
                end
            end
            if (nic_ack && job_q.size() != 0) begin
                j = job_q.pop_front();
                if (j.ptype == PT_RD) rep_q.push_back({PT_RDACK, 4'd0, j.sid, id, j.sel, j.adr, nic_dati});
            end
            if (newjob) job_q.push_back(p);

            tick();
            n_cmp++; if (pkt_o !== e_pkt) begin n_bad++; $display("FAIL rnd_pkt_o c%0d got %h want %h", c, pkt_o, e_pkt); end
            n_cmp++; if ({tx_ack, rx_valid} !== {e_tx, e_rx}) begin n_bad++; $display("FAIL rnd_pulses c%0d got %b want %b", c, {tx_ack, rx_valid}, {e_tx, e_rx}); end
            if (e_rx) begin
                n_cmp++; if ({rx_sid, rx_dat} !== {e_rxsid, e_rxdat}) begin n_bad++; $display("FAIL rnd_rx c%0d got %h/%h want %h/%h", c, rx_sid, rx_dat, e_rxsid, e_rxdat); end
            end
            n_cmp++; if (drop_cnt !== 16'(dropm)) begin n_bad++; $display("FAIL rnd_drop c%0d got %0d want %0d", c, drop_cnt, dropm); end
            n_cmp++; if ({nic_cyc, nic_stb} !== {2{job_q.size() != 0}}) begin n_bad++; $display("FAIL rnd_cyc c%0d got %b want %0d", c, {nic_cyc, nic_stb}, job_q.size()); end
            if (newjob) begin
                n_cmp++; if ({nic_adr, nic_we, nic_sel, nic_dato} !== {8'hFF, id, p.adr[19:0], p.ptype == PT_WR, p.sel, p.dat}) begin
                    n_bad++; $display("FAIL rnd_wb c%0d got %h %b %h %h", c, nic_adr, nic_we, nic_sel, nic_dato); end
            end
            acked_prev = tx_ack;
            if (tx_ack) tx_req = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_remote_write();
        test_remote_read();
        test_busy_forward();
        test_age_out();
        test_contention();
        test_tx_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rf68000_nic_ring.md
# rf68000_nic_ring

Ring network interface for one rf68000 node; sits directly upstream of the node arbiter and drives its nic_* Wishbone master port. Each cycle it takes one packet slot from the upstream neighbour and either consumes it (remote read/write into this node's RAM, or a read reply for the local CPU) or forwards it downstream. It also injects locally originated requests and generated read replies into empty slots.

## Interface
- ID_W, 4, node id width; id 4'hF is reserved for broadcast
- AGE_MAX, 4'd15, age at which an unconsumed packet is dropped
- Packet layout, 84 bits, MSB first: type[3:0], age[3:0], did[3:0], sid[3:0], sel[3:0], adr[31:0], dat[31:0]
- Packet types: PT_NOP=0, PT_WR=1, PT_RD=2, PT_RDACK=3; any other value is treated as PT_NOP

- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active low
- id  in  4  this node's id
- pkt_i  in  84  slot from upstream node
- pkt_o  out  84  registered slot to downstream node
- nic_cyc, nic_stb, nic_we  out  1  Wishbone master to node arbiter
- nic_sel  out  4  byte selects
- nic_adr  out  32  always {8'hFF, id, pkt.adr[19:0]}
- nic_dato  out  32  write data
- nic_ack  in  1  from arbiter
- nic_dati  in  32  read data from arbiter
- tx_req  in  1  local request pending; tx_type, tx_did, tx_sel, tx_adr, tx_dat held stable while tx_req is high
- tx_type  in  4  tx_did in 4  tx_sel in 4  tx_adr in 32  tx_dat in 32
- tx_ack  out  1  one-cycle pulse when the local request is injected
- rx_valid  out  1  one-cycle pulse when a PT_RDACK addressed to this node arrives
- rx_sid  out  4  rx_dat out 32  reply source and data, valid with rx_valid
- drop_cnt  out  16  saturating count of aged-out packets

## Operation
- Reset (rst_ni=0 at a clock edge): pkt_o=0 (NOP); nic_cyc/stb/we=0; nic_sel/adr/dato=0; tx_ack=0; rx_valid=0; rx_sid/rx_dat=0; drop_cnt=0; FSM to ST_IDLE. Any in-flight Wishbone cycle is abandoned, and any held response is discarded.
- Incoming slot classification, in priority order:
  - NOP: slot is free.
  - did==id with PT_RDACK: latch rx_sid/rx_dat, pulse rx_valid; slot is free.
  - did==id with PT_WR/PT_RD and FSM in ST_IDLE: capture into the request register, start a Wishbone cycle; slot is free.
  - did==id with the FSM busy: forward with age+1 (the packet circulates the ring and retries).
  - Otherwise: forward with age+1. If age==AGE_MAX, drop instead, free the slot and increment drop_cnt (saturating at 16'hFFFF).
- Free-slot fill priority: held response first, then local tx. tx_ack pulses in the cycle pkt_o is loaded with {tx_type, 4'd0, tx_did, id, tx_sel, tx_adr, tx_dat}.
- FSM:
  - ST_IDLE: on capture, go to ST_WB.
  - ST_WB: nic_cyc=stb=1; nic_we=1 for PT_WR; nic_sel=pkt.sel. On nic_ack, drop cyc/stb in the same edge. PT_WR goes to ST_IDLE. PT_RD latches nic_dati and goes to ST_RESP.
  - ST_RESP: hold {PT_RDACK, 0, sid, id, sel, adr, data}. Once injected, go to ST_IDLE.
- The arbiter also acks out-of-range addresses immediately. The NIC does not distinguish this case.

## Timing
- Forward latency: 1 cycle from pkt_i to pkt_o.
- Capture edge to nic_cyc high: 1 cycle. nic_cyc stays high until the edge at which nic_ack is sampled high. Arbiter round trip is about 5 cycles.
- Simultaneous events:
  - Response ready and a free slot: the response wins, and tx waits.
  - Incoming packet for this node arriving on the same edge the FSM returns to ST_IDLE: the FSM is still busy that cycle, so the packet is forwarded.
  - rx_valid can pulse in the same cycle as tx_ack.
- tx_req deasserted before tx_ack: nothing is injected, and there is no partial state.

## Configuration
- RF68000_NIC_BCAST_EN defined: a PT_WR with did==4'hF and sid!=id is captured as a local write (when ST_IDLE) and is also forwarded with age+1. A broadcast write with sid==id has completed the ring and is consumed (slot freed).
- RF68000_NIC_BCAST_EN undefined: did==4'hF is an ordinary non-matching id, so broadcasts simply age out.

## Structure
- Shared package rf68000_nic_pkg: the packet struct typedef, the packet-type enum, AGE_MAX, and the broadcast id constant. The ring switch and the CPU side reuse this package.
- One sub-module, rf68000_nic_slot_mux: combinational free-slot selection (forward / response / tx) plus the age update. The FSM and Wishbone logic stay in the top module.

## Test plan
- Remote write: id=3, pkt_i={WR,0,3,1,F,0x00000100,0xDEADBEEF} → nic_adr=0xFF300100, nic_we=1, nic_dato=0xDEADBEEF. pkt_o is NOP the next cycle.
- Remote read: pkt {RD,0,3,5,F,0x40,x}, arbiter returns 0x12345678 → pkt_o={RDACK,0,5,3,F,0x40,0x12345678} in the first free slot after ack.
- Busy forwarding: a second PT_WR to id 3 arrives while in ST_WB → it is forwarded with age+1, and no second nic cycle occurs.
- Age-out: pkt {WR,15,7,1,...} at node 3 → pkt_o=NOP and drop_cnt 0→1. Same packet with age 14 → forwarded with age 15.
- Contention: response pending, tx_req=1, pkt_i NOP → response injected first, and tx_ack pulses on the next free slot.
- Reset mid-cycle: rst_ni low during ST_WB → nic_cyc=0, pkt_o=0, and the FSM is in ST_IDLE the next cycle.
